// File: rtl/tetris_input_ctrl.sv
// Turns held-key levels into one-cycle game-action pulses: DAS/ARR on left/right, fixed repeat on down, one-shot rotate/drop.
// Define TETRIS_LAST_DIR_WINS_EN to let the newest horizontal press win instead of cancelling both directions.
module tetris_input_ctrl #(
   parameter int DAS_DELAY   = 16_000_000,
   parameter int ARR_PERIOD  = 4_000_000,
   parameter int SOFT_PERIOD = 3_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic key_left,
   input  logic key_right,
   input  logic key_down,
   input  logic key_rotate,
   input  logic key_drop,
   output logic act_left,
   output logic act_right,
   output logic act_down,
   output logic act_rotate,
   output logic act_drop
);

   localparam int MAX_HA = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
   localparam int MAX_P  = (MAX_HA > SOFT_PERIOD) ? MAX_HA : SOFT_PERIOD;
   localparam int CW     = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] DAS_LD  = CW'(DAS_DELAY - 1);
   localparam logic [CW-1:0] ARR_LD  = CW'(ARR_PERIOD - 1);
   localparam logic [CW-1:0] SOFT_LD = CW'(SOFT_PERIOD - 1);

   typedef enum logic [1:0] {H_IDLE, H_DAS, H_REPEAT} h_state_t;
   typedef enum logic {S_IDLE, S_REPEAT} s_state_t;

   logic [4:0] key;
   logic [4:0] prev;
   logic [4:0] press;

   assign key   = {key_drop, key_rotate, key_down, key_right, key_left};
   assign press = key & ~prev;

   // Index 0 is left, index 1 is right.
   h_state_t         h_state    [2];
   h_state_t         h_state_nx [2];
   logic [1:0][CW-1:0] h_cnt;
   logic [1:0][CW-1:0] h_cnt_nx;
   logic [1:0]       h_pulse;
   logic [1:0]       allow;
   logic [1:0]       blk;
   logic [1:0]       trig;

   s_state_t         s_state;
   s_state_t         s_state_nx;
   logic [CW-1:0]    s_cnt;
   logic [CW-1:0]    s_cnt_nx;
   logic             s_pulse;

`ifdef TETRIS_LAST_DIR_WINS_EN
   logic own_l;
   logic own_l_nx;

   // A fresh press claims the channel; left wins a same-cycle tie.
   always_comb begin
      own_l_nx = own_l;
      if (press[0])
         own_l_nx = 1'b1;
      else if (press[1])
         own_l_nx = 1'b0;
   end

   assign allow[0] = key_left  & (~key_right | own_l_nx);
   assign allow[1] = key_right & (~key_left  | ~own_l_nx);
`else
   assign allow[0] = key_left  & ~key_right;
   assign allow[1] = key_right & ~key_left;
`endif

   // A direction that was held but blocked last cycle restarts as a fresh press once it is allowed again.
   assign trig = allow & (press[1:0] | blk);

   always_comb begin
      h_pulse = 2'b00;
      for (int i = 0; i < 2; i++) begin
         h_state_nx[i] = h_state[i];
         h_cnt_nx[i]   = h_cnt[i];
         if (!en || !allow[i]) begin
            h_state_nx[i] = H_IDLE;
            h_cnt_nx[i]   = '0;
         end else begin
            case (h_state[i])
               H_IDLE: begin
                  if (trig[i]) begin
                     h_pulse[i]    = 1'b1;
                     h_cnt_nx[i]   = DAS_LD;
                     h_state_nx[i] = H_DAS;
                  end
               end
               H_DAS: begin
                  if (h_cnt[i] == '0) begin
                     h_pulse[i]    = 1'b1;
                     h_cnt_nx[i]   = ARR_LD;
                     h_state_nx[i] = H_REPEAT;
                  end else begin
                     h_cnt_nx[i] = h_cnt[i] - CW'(1);
                  end
               end
               H_REPEAT: begin
                  if (h_cnt[i] == '0) begin
                     h_pulse[i]  = 1'b1;
                     h_cnt_nx[i] = ARR_LD;
                  end else begin
                     h_cnt_nx[i] = h_cnt[i] - CW'(1);
                  end
               end
               default: begin
                  h_state_nx[i] = H_IDLE;
                  h_cnt_nx[i]   = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      s_state_nx = s_state;
      s_cnt_nx   = s_cnt;
      s_pulse    = 1'b0;
      if (!en || !key_down) begin
         s_state_nx = S_IDLE;
         s_cnt_nx   = '0;
      end else begin
         case (s_state)
            S_IDLE: begin
               if (press[2]) begin
                  s_pulse    = 1'b1;
                  s_cnt_nx   = SOFT_LD;
                  s_state_nx = S_REPEAT;
               end
            end
            S_REPEAT: begin
               if (s_cnt == '0) begin
                  s_pulse  = 1'b1;
                  s_cnt_nx = SOFT_LD;
               end else begin
                  s_cnt_nx = s_cnt - CW'(1);
               end
            end
            default: begin
               s_state_nx = S_IDLE;
               s_cnt_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev       <= '0;
         blk        <= '0;
         h_state[0] <= H_IDLE;
         h_state[1] <= H_IDLE;
         h_cnt      <= '0;
         s_state    <= S_IDLE;
         s_cnt      <= '0;
         act_left   <= 1'b0;
         act_right  <= 1'b0;
         act_down   <= 1'b0;
         act_rotate <= 1'b0;
         act_drop   <= 1'b0;
`ifdef TETRIS_LAST_DIR_WINS_EN
         own_l      <= 1'b0;
`endif
      end else begin
         // Edge history and blocking history track every cycle, even with en low.
         prev       <= key;
         blk        <= {key_right, key_left} & ~allow;
         h_state[0] <= h_state_nx[0];
         h_state[1] <= h_state_nx[1];
         h_cnt      <= h_cnt_nx;
         s_state    <= s_state_nx;
         s_cnt      <= s_cnt_nx;
         act_left   <= h_pulse[0];
         act_right  <= h_pulse[1];
         act_down   <= s_pulse;
         act_rotate <= en & press[3];
         act_drop   <= en & press[4];
`ifdef TETRIS_LAST_DIR_WINS_EN
         own_l      <= own_l_nx;
`endif
      end
   end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with DAS_DELAY=10, ARR_PERIOD=4, SOFT_PERIOD=3; expected act vectors are queued per cycle.
module tb_tetris_input_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic key_left, key_right, key_down, key_rotate, key_drop;
   logic act_left, act_right, act_down, act_rotate, act_drop;

   int n_cmp = 0;
   int n_err = 0;
   string cur_tag = "init";
   int cur_cyc = 0;
   logic [4:0] exp_q [$];

   tetris_input_ctrl #(
      .DAS_DELAY  (10),
      .ARR_PERIOD (4),
      .SOFT_PERIOD(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .key_left  (key_left),
      .key_right (key_right),
      .key_down  (key_down),
      .key_rotate(key_rotate),
      .key_drop  (key_drop),
      .act_left  (act_left),
      .act_right (act_right),
      .act_down  (act_down),
      .act_rotate(act_rotate),
      .act_drop  (act_drop)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   // k = {drop, rotate, down, right, left}; exp is the act vector required in the following cycle.
   task automatic step(input logic [4:0] k, input logic e, input logic r, input logic [4:0] exp);
      logic [4:0] got;
      logic [4:0] want;
      @(negedge clk);
      {key_drop, key_rotate, key_down, key_right, key_left} = k;
      en  = e;
      rst = r;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      got  = {act_drop, act_rotate, act_down, act_right, act_left};
      want = exp_q.pop_front();
      n_cmp++;
      assert (got === want)
      else begin
         n_err++;
         $error("FAIL %s cyc %0d: act{drop,rot,down,right,left} got %b expected %b",
                cur_tag, cur_cyc + 1, got, want);
      end
   endtask

   function automatic logic [4:0] expv(input int c, input logic [63:0] ml, input logic [63:0] mr,
                                       input logic [63:0] md, input logic [63:0] mo,
                                       input logic [63:0] mp);
      return {mp[c+1], mo[c+1], md[c+1], mr[c+1], ml[c+1]};
   endfunction

   task automatic gap();
      cur_tag = "gap";
      for (int i = 0; i < 2; i++) begin
         cur_cyc = i;
         step(5'b00000, 1'b1, 1'b0, 5'b00000);
      end
   endtask

   logic [63:0] ml, mr, md, mo, mp;

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      {key_drop, key_rotate, key_down, key_right, key_left} = 5'b00000;

      cur_tag = "reset_state";
      for (int i = 0; i < 2; i++) begin
         cur_cyc = i;
         step(5'b00000, 1'b1, 1'b1, 5'b00000);
      end
      gap();

      // Left held 25 cycles: 1, 11, 15, 19, 23.
      cur_tag = "left_das_arr";
      ml = '0; ml[1] = 1; ml[11] = 1; ml[15] = 1; ml[19] = 1; ml[23] = 1;
      for (int c = 0; c < 30; c++) begin
         cur_cyc = c;
         step({4'b0000, c < 25}, 1'b1, 1'b0, expv(c, ml, '0, '0, '0, '0));
      end
      gap();

      // Down held 10 cycles, rotate held 20 cycles.
      cur_tag = "down_rotate";
      md = '0; md[1] = 1; md[4] = 1; md[7] = 1; md[10] = 1;
      mo = '0; mo[1] = 1;
      for (int c = 0; c < 24; c++) begin
         cur_cyc = c;
         step({1'b0, c < 20, c < 10, 2'b00}, 1'b1, 1'b0, expv(c, '0, '0, md, mo, '0));
      end
      gap();

      // Opposite directions: left from 0, right from 5, left released at 8.
      cur_tag = "opposite_dirs";
      ml = '0; ml[1] = 1;
      mr = '0;
`ifdef TETRIS_LAST_DIR_WINS_EN
      mr[6] = 1; mr[16] = 1; mr[20] = 1;
`else
      mr[9] = 1; mr[19] = 1;
`endif
      for (int c = 0; c < 22; c++) begin
         cur_cyc = c;
         step({3'b000, c >= 5, c < 8}, 1'b1, 1'b0, expv(c, ml, mr, '0, '0, '0));
      end
      gap();

      // Drop held while en low, en rises at 5, release 10-11, re-press at 12.
      cur_tag = "drop_en";
      mp = '0; mp[13] = 1;
      for (int c = 0; c < 18; c++) begin
         cur_cyc = c;
         step({(c < 10) || (c >= 12 && c < 16), 4'b0000}, c >= 5, 1'b0,
              expv(c, '0, '0, '0, '0, mp));
      end
      gap();

      // en dropped mid-hold kills the pending DAS repeat.
      cur_tag = "en_mid_hold";
      ml = '0; ml[1] = 1;
      for (int c = 0; c < 16; c++) begin
         cur_cyc = c;
         step({4'b0000, c < 12}, !(c == 3 || c == 4), 1'b0, expv(c, ml, '0, '0, '0, '0));
      end
      gap();

      // Right held, rst at cycle 7: pulses 1, 9, 19.
      cur_tag = "rst_mid_hold";
      mr = '0; mr[1] = 1; mr[9] = 1; mr[19] = 1;
      for (int c = 0; c < 22; c++) begin
         cur_cyc = c;
         step({3'b000, 1'b1, 1'b0}, 1'b1, c == 7, expv(c, '0, mr, '0, '0, '0));
      end
      gap();

      // Same-cycle press of rotate, drop and down.
      cur_tag = "simultaneous";
      md = '0; md[1] = 1;
      mo = '0; mo[1] = 1;
      mp = '0; mp[1] = 1;
      for (int c = 0; c < 5; c++) begin
         cur_cyc = c;
         step({c < 2, c < 2, c < 2, 2'b00}, 1'b1, 1'b0, expv(c, '0, '0, md, mo, mp));
      end
      gap();

      n_cmp++;
      assert (exp_q.size() === 0)
      else begin
         n_err++;
         $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
